// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and FSM encoding for the write-back stage
package wb_pkg;

  localparam logic [1:0] ALU_OUT = 2'd0;
  localparam logic [1:0] IMM_DAT = 2'd1;
  localparam logic [1:0] MEM_DAT = 2'd2;
  localparam logic [1:0] PC_NEXT = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and sign/zero-extends the addressed byte or halfword of a load word
module load_align
  import wb_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    // offset[0] is ignored for halfwords: misaligned halves trap before reaching here
    half_sel = offset[1] ? raw[31:16] : raw[15:0];

    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'd0, half_sel};
      F3_LW:   data = raw;
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/write_back_unit.sv
// rtl/write_back_unit.sv - handshaked write-back stage: result select, load wait/align, RF write, instret
module write_back_unit
  import wb_pkg::*;
#(
  parameter int          REG_AW  = 5,
  parameter int          CNT_W   = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        wb_sel,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       immediate,
  input  logic [31:0]       pc_next,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_off,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              reg_we_in,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  input  logic              flush,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              pend_valid,
  output logic [REG_AW-1:0] pend_rd,
  output logic              ld_err,
  output logic [CNT_W-1:0]  instret
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  wb_state_e         state, state_nxt;
  logic [REG_AW-1:0] rd_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [TW-1:0]     tmo_cnt;
  logic [31:0]       aligned;
  logic [31:0]       sel_value;
  logic              tmo_hit;
  logic              load_go, tmo_inc, commit, commit_we, err_nxt;
  logic [REG_AW-1:0] commit_rd;
  logic [31:0]       commit_data;

  load_align u_align (
    .funct3 (f3_q),
    .offset (off_q),
    .raw    (mem_rsp_data),
    .data   (aligned)
  );

  always_comb begin
    case (wb_sel)
      IMM_DAT: sel_value = immediate;
      PC_NEXT: sel_value = pc_next;
      default: sel_value = alu_result;
    endcase
  end

  // This cycle is the TIMEOUT-th one spent waiting without a response
  assign tmo_hit = (TIMEOUT != 0) && ((32'(tmo_cnt) + 32'd1) == 32'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = (state == ST_IDLE) && !flush;
    load_go     = 1'b0;
    tmo_inc     = 1'b0;
    commit      = 1'b0;
    commit_we   = 1'b0;
    commit_rd   = rd_q;
    commit_data = aligned;
    err_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          if (wb_sel == MEM_DAT) begin
            load_go   = 1'b1;
            state_nxt = ST_WAIT_MEM;
          end else begin
            commit      = 1'b1;
            commit_we   = reg_we_in && (rd_in != '0);
            commit_rd   = rd_in;
            commit_data = sel_value;
          end
        end
      end
      ST_WAIT_MEM: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (mem_rsp_valid) begin
          commit    = 1'b1;
          commit_we = we_q;
          state_nxt = ST_IDLE;
        end else if (tmo_hit) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      we_q     <= 1'b0;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      tmo_cnt  <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= 32'd0;
      ld_err   <= 1'b0;
      instret  <= '0;
    end else begin
      rf_we  <= commit_we;
      ld_err <= err_nxt;
      if (load_go) begin
        rd_q    <= rd_in;
        we_q    <= reg_we_in && (rd_in != '0);
        f3_q    <= ld_funct3;
        off_q   <= ld_off;
        tmo_cnt <= '0;
      end else if (tmo_inc) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (commit_we) begin
        rf_waddr <= commit_rd;
        rf_wdata <= commit_data;
      end
      if (commit) instret <= instret + 1'b1;
    end
  end

  assign pend_valid = (state == ST_WAIT_MEM) && we_q;
  assign pend_rd    = pend_valid ? rd_q : '0;

endmodule
